button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Input-side front end for the stopwatch `top`. It receives the four raw, asynchronous, bouncing push-button levels (one, ten, pause, clear). For each button it synchronizes, debounces and converts the press into a single-cycle command pulse. Simultaneous presses are arbitrated into one encoded command for the stopwatch FSM. It sits between the board pins and the FSM, replacing direct button-level sampling.

Parameters:
DEBOUNCE_CYCLES, 100_000, consecutive stable synchronized cycles required to accept a level change (10 ms at 10 MHz); legal range 2..500_000, so it stays below the 1_000_000-cycle minimum press.
CNT_W, $clog2(DEBOUNCE_CYCLES), width of each debounce counter.

Ports:
clk  input  1  system clock, 10 MHz.
rst  input  1  asynchronous, active-high reset.
one_button  input  1  raw 1-second-mode button, asynchronous, active-high.
ten_button  input  1  raw 10-second-mode button.
pause_button  input  1  raw pause button.
clear_button  input  1  raw clear button.
btn_level  output  4  debounced levels {clear, pause, ten, one}.
cmd_valid  output  1  one-cycle strobe; a command was accepted.
cmd  output  2  encoded command, valid only when cmd_valid=1: 0=ONE, 1=TEN, 2=PAUSE, 3=CLEAR.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-high.
  - On rst: all synchronizer flops = 0, btn_level = 0, cmd_valid = 0, cmd = 0, every channel in RELEASED with count = 0.
- Per channel: 2-flop synchronizer (sync1, sync2), then a debounce FSM with states RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK and a counter.
  - RELEASED: sync2=1 -> PRESS_CHK, count<=1; else stay.
  - PRESS_CHK: sync2=0 -> RELEASED, count<=0 (bounce rejected). sync2=1 and count==DEBOUNCE_CYCLES-1 -> PRESSED, count<=0, raise a press event. Otherwise count++.
  - PRESSED: sync2=0 -> RELEASE_CHK, count<=1; else stay.
  - RELEASE_CHK: sync2=1 -> PRESSED, count<=0. sync2=0 and count==DEBOUNCE_CYCLES-1 -> RELEASED, count<=0. Otherwise count++. Release produces no event.
- btn_level[i] = 1 in PRESSED and RELEASE_CHK, else 0.
- Latency: let edge 1 be the first edge at which sync1 samples a steady high raw input.
  - The channel enters PRESSED at edge DEBOUNCE_CYCLES+2.
  - cmd_valid/cmd are registered and are high for exactly the one cycle following that edge.
- Exactly one event per accepted press, regardless of hold length; a hold of 1_000_000 cycles yields one pulse.
- Arbitration when several press events occur on the same edge:
  - Priority is CLEAR > PAUSE > TEN > ONE.
  - Only the winner is emitted; losers are dropped, not queued.
  - Levels of losing channels still update normally.
- Events on different edges are each emitted, even when only one cycle apart.
- Reset mid-press: the FSM returns to RELEASED. A button still held after rst deasserts is treated as a new press, producing a pulse DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles never change btn_level or produce cmd_valid.

Decomposition:
- Shared package stopwatch_pkg holds:
  - btn_state_t enum {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK};
  - cmd_t enum {CMD_ONE=2'd0, CMD_TEN=2'd1, CMD_PAUSE=2'd2, CMD_CLEAR=2'd3};
  - DEBOUNCE_DEFAULT = 100_000;
  - CLK_HZ = 10_000_000.
- One sub-module, button_debouncer (synchronizer + FSM + counter; outputs level and press_evt), instantiated 4 times.
- The parent contains only the arbiter and the output registers.

Test Plan:
- Clean press, DEBOUNCE_CYCLES=8: one_button high for 100 cycles -> cmd_valid=1, cmd=0 for exactly one cycle, 10 edges after the first sampling edge; btn_level[0]=1 from that cycle. After release, btn_level[0]=0 ten edges later with no pulse.
- Bounce, D=8: ten_button toggles every 3 cycles for 30 cycles, then holds high -> no cmd_valid during toggling; exactly one cmd=1 pulse 10 edges after the final rising edge.
- Simultaneous presses, D=8: one, pause and clear rise on the same cycle -> single cmd_valid with cmd=3; btn_level=4'b1101 afterwards; no later pulse for one or pause.
- Reset mid-operation: assert rst while pause_button is in PRESS_CHK (count=4) -> outputs 0 immediately. Deassert rst with the button still high -> cmd=2 pulse 10 edges after the first post-reset edge.
- Default parameter, stopwatch timing: press_one (1_000_000 cycles high), then press_pause -> exactly two pulses, cmd=0 then cmd=2, each 100_002 edges after its rising input; btn_level returns to 0 100_002 edges after each release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch input front end.
// Debounce FSM states, encoded commands and default timing.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  typedef enum logic [1:0] {
    CMD_ONE   = 2'd0,
    CMD_TEN   = 2'd1,
    CMD_PAUSE = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_t;

  localparam int unsigned DEBOUNCE_DEFAULT = 100_000;
  localparam int unsigned CLK_HZ           = 10_000_000;

  localparam int unsigned NUM_BTN = 4;

  // Index of each button inside the level / event vectors.
  localparam int unsigned BTN_ONE   = 0;
  localparam int unsigned BTN_TEN   = 1;
  localparam int unsigned BTN_PAUSE = 2;
  localparam int unsigned BTN_CLEAR = 3;

  function automatic logic is_down(input btn_state_t s);
    return (s == PRESSED) || (s == RELEASE_CHK);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button channel: 2-flop synchronizer, debounce FSM and counter.
// Emits a single-cycle press event when a press is accepted.
module button_debouncer
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_evt_o
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  btn_state_t       state_q;
  btn_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          state_d = PRESS_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_CHK: begin
        if (!sync2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_last) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASE_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_CHK: begin
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_last) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    level_o     = is_down(state_q);
    press_evt_o = (state_q == PRESS_CHK) && sync2_q && cnt_last;
  end

endmodule

// File: rtl/button_conditioner.sv
// Four debounced button channels with a fixed-priority command arbiter.
// Same-edge press events collapse to the highest-priority command.
module button_conditioner
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       one_button,
  input  logic       ten_button,
  input  logic       pause_button,
  input  logic       clear_button,
  output logic [3:0] btn_level,
  output logic       cmd_valid,
  output logic [1:0] cmd
);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] evt;

  logic cmd_valid_q;
  logic cmd_valid_d;
  cmd_t cmd_q;
  cmd_t cmd_d;

  assign raw = {clear_button, pause_button, ten_button, one_button};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk        (clk),
      .rst        (rst),
      .btn_raw_i  (raw[i]),
      .level_o    (level[i]),
      .press_evt_o(evt[i])
    );
  end

  // Losers on the same edge are dropped, not queued.
  always_comb begin
    cmd_valid_d = |evt;
    cmd_d       = CMD_ONE;
    case (1'b1)
      evt[BTN_CLEAR]: cmd_d = CMD_CLEAR;
      evt[BTN_PAUSE]: cmd_d = CMD_PAUSE;
      evt[BTN_TEN]:   cmd_d = CMD_TEN;
      evt[BTN_ONE]:   cmd_d = CMD_ONE;
      default:        cmd_d = CMD_ONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_ONE;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
    end
  end

  assign btn_level = level;
  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with an 8-cycle debounce window.
// Expected timings are derived by hand from the channel latency D+2.
module tb_button_conditioner;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       one_b = 1'b0;
  logic       ten_b = 1'b0;
  logic       pause_b = 1'b0;
  logic       clear_b = 1'b0;
  logic [3:0] btn_level;
  logic       cmd_valid;
  logic [1:0] cmd;

  int vecs = 0;
  int errs = 0;
  int p;

  button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .one_button  (one_b),
    .ten_button  (ten_b),
    .pause_button(pause_b),
    .clear_button(clear_b),
    .btn_level   (btn_level),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (cmd_valid === 1'b1) pulses++;
    end
  endtask

  // Inputs were changed just after an edge: the next edge is edge 1.
  task automatic expect_pulse(input string tag, input int c,
                              input int lvl);
    int q;
    run(D + 1, q);
    check({tag, "_early"}, q, 0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, int'(cmd_valid), 1);
    check({tag, "_cmd"}, int'(cmd), c);
    check({tag, "_lvl"}, int'(btn_level), lvl);
    @(posedge clk);
    #1;
    check({tag, "_once"}, int'(cmd_valid), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_lvl", int'(btn_level), 0);
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_cmd", int'(cmd), 0);
    rst = 1'b0;
    run(4, p);

    // Clean press of ONE, held 100 cycles
    one_b = 1'b1;
    expect_pulse("one", 0, 4'b0001);
    run(88, p);
    check("one_hold_pulses", p, 0);
    check("one_hold_lvl", int'(btn_level), 1);
    one_b = 1'b0;
    run(D + 1, p);
    check("one_rel_pulses", p, 0);
    check("one_rel_lvl_hi", int'(btn_level), 1);
    run(1, p);
    check("one_rel_lvl_lo", int'(btn_level), 0);
    check("one_rel_nopulse", p, 0);
    run(5, p);

    // Bouncing TEN: 3-cycle high/low segments for 30 cycles
    for (int s = 0; s < 10; s++) begin
      ten_b = (s % 2 == 0);
      run(3, p);
      check("ten_bounce_pulses", p, 0);
    end
    check("ten_bounce_lvl", int'(btn_level), 0);
    ten_b = 1'b1;
    expect_pulse("ten", 1, 4'b0010);
    ten_b = 1'b0;
    run(20, p);
    check("ten_rel_lvl", int'(btn_level), 0);

    // Simultaneous ONE, PAUSE, CLEAR
    one_b   = 1'b1;
    pause_b = 1'b1;
    clear_b = 1'b1;
    expect_pulse("simul", 3, 4'b1101);
    run(30, p);
    check("simul_no_later", p, 0);
    check("simul_lvl", int'(btn_level), 4'b1101);
    one_b   = 1'b0;
    pause_b = 1'b0;
    clear_b = 1'b0;
    run(20, p);
    check("simul_rel_lvl", int'(btn_level), 0);

    // Reset while PAUSE is in PRESS_CHK with count=4
    pause_b = 1'b1;
    run(6, p);
    rst = 1'b1;
    #1;
    check("mid_rst_lvl", int'(btn_level), 0);
    check("mid_rst_valid", int'(cmd_valid), 0);
    check("mid_rst_cmd", int'(cmd), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_pulse("post_rst", 2, 4'b0100);
    pause_b = 1'b0;
    run(20, p);

    // Events on consecutive edges are both emitted
    one_b = 1'b1;
    run(1, p);
    ten_b = 1'b1;
    run(D, p);
    check("adj_early", p, 0);
    run(1, p);
    check("adj_first_v", int'(cmd_valid), 1);
    check("adj_first_c", int'(cmd), 0);
    run(1, p);
    check("adj_second_v", int'(cmd_valid), 1);
    check("adj_second_c", int'(cmd), 1);
    run(1, p);
    check("adj_done", int'(cmd_valid), 0);
    one_b = 1'b0;
    ten_b = 1'b0;
    run(20, p);

    // Glitch of D-1 cycles is rejected
    clear_b = 1'b1;
    run(D - 1, p);
    clear_b = 1'b0;
    run(20, p);
    check("glitch_pulses", p, 0);
    check("glitch_lvl", int'(btn_level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
